// File: rtl/riscv_regs_bank_if.sv
// Write-enable encoding and the bus bundle (write port, packed read ports, status)
// shared by the register bank and whatever drives it.
package riscv_regs_bank_pkg;
  typedef enum logic {
    RF_NOWRITE = 1'b0,
    RF_WRITE   = 1'b1
  } RF_WEN;
endpackage

interface riscv_regs_bank_if
  import riscv_regs_bank_pkg::*;
#(
  parameter int unsigned WORD_LENGTH    = 32,
  parameter int unsigned ADDR_LENGTH    = 5,
  parameter int unsigned NUM_READ_PORTS = 2
);
  RF_WEN                              write_en;
  logic [ADDR_LENGTH-1:0]             write_addr;
  logic [WORD_LENGTH-1:0]             data;
  logic [NUM_READ_PORTS*ADDR_LENGTH-1:0] read_addr;
  logic [NUM_READ_PORTS*WORD_LENGTH-1:0] read_data;
  logic                               ready;
  logic                               debug;

  modport master (
    output write_en, write_addr, data, read_addr,
    input  read_data, ready, debug
  );

  modport slave (
    input  write_en, write_addr, data, read_addr,
    output read_data, ready, debug
  );
endinterface

// File: rtl/riscv_regs_bank.sv
// Register file with x0 hardwired to zero, multiple combinational read ports,
// optional write-to-read forwarding and a one-register-per-edge clear after reset.
module riscv_regs_bank
  import riscv_regs_bank_pkg::*;
#(
  parameter int unsigned WORD_LENGTH    = 32,
  parameter int unsigned ADDR_LENGTH    = 5,
  parameter int unsigned NUM_REGS       = 32,
  parameter int unsigned NUM_READ_PORTS = 2,
  parameter int unsigned BYPASS         = 1,
  parameter int unsigned DEBUG_REG      = 3
) (
  input logic clk,
  input logic rst,
  riscv_regs_bank_if.slave bus
);

  typedef enum logic {
    StClear,
    StRun
  } state_e;

  localparam logic [ADDR_LENGTH-1:0] LastIdx = ADDR_LENGTH'(NUM_REGS - 1);

  state_e                 state_q, state_d;
  logic [ADDR_LENGTH-1:0] clr_idx_q, clr_idx_d;
  logic                   ready_q;

  logic [WORD_LENGTH-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:0]    reg_we;
  logic [WORD_LENGTH-1:0] reg_wd;
  logic                   wr_fire;

  logic [ADDR_LENGTH-1:0] rd_addr [NUM_READ_PORTS];
  logic [WORD_LENGTH-1:0] rd_val  [NUM_READ_PORTS];

  // x0 and out-of-range destinations never fire, so they cannot alias onto real registers.
  always_comb begin
    wr_fire = (state_q == StRun) && (bus.write_en == RF_WRITE) &&
              (bus.write_addr != '0) && (32'(bus.write_addr) < NUM_REGS);
  end

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    case (state_q)
      StClear: begin
        clr_idx_d = clr_idx_q + ADDR_LENGTH'(1);
        if (clr_idx_q == LastIdx) state_d = StRun;
      end
      StRun:   state_d = StRun;
      default: state_d = StClear;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StClear;
      clr_idx_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      ready_q   <= (state_d == StRun);
    end
  end

  always_comb begin
    reg_we = '0;
    reg_wd = (state_q == StClear) ? '0 : bus.data;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      if (state_q == StClear) reg_we[i] = (clr_idx_q == ADDR_LENGTH'(i));
      else                    reg_we[i] = wr_fire && (bus.write_addr == ADDR_LENGTH'(i));
    end
  end

  // Contents are deliberately left untouched while rst is held.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        if (reg_we[i]) regs[i] <= reg_wd;
      end
    end
  end

  always_comb begin
    for (int p = 0; p < int'(NUM_READ_PORTS); p++) begin
      rd_addr[p] = bus.read_addr[p*ADDR_LENGTH +: ADDR_LENGTH];
      rd_val[p]  = '0;
      for (int i = 1; i < int'(NUM_REGS); i++) begin
        if (rd_addr[p] == ADDR_LENGTH'(i)) rd_val[p] = regs[i];
      end
      if ((BYPASS != 0) && wr_fire && (rd_addr[p] == bus.write_addr)) rd_val[p] = bus.data;
      if (state_q != StRun) rd_val[p] = '0;
    end
  end

  always_comb begin
    bus.read_data = '0;
    for (int p = 0; p < int'(NUM_READ_PORTS); p++) begin
      bus.read_data[p*WORD_LENGTH +: WORD_LENGTH] = rd_val[p];
    end
  end

  assign bus.ready = ready_q;

  if (DEBUG_REG < NUM_REGS) begin : g_debug
    assign bus.debug = (state_q == StRun) && regs[DEBUG_REG][0];
  end else begin : g_no_debug
    assign bus.debug = 1'b0;
  end

endmodule

// File: tb/tb_riscv_regs_bank.sv
// Directed bench for three bank configurations: default, BYPASS=0, and 16 regs / 3 ports.
module tb_riscv_regs_bank;
  import riscv_regs_bank_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  riscv_regs_bank_if #(.WORD_LENGTH(32), .ADDR_LENGTH(5), .NUM_READ_PORTS(2)) if_a ();
  riscv_regs_bank_if #(.WORD_LENGTH(32), .ADDR_LENGTH(5), .NUM_READ_PORTS(2)) if_c ();
  riscv_regs_bank_if #(.WORD_LENGTH(32), .ADDR_LENGTH(5), .NUM_READ_PORTS(3)) if_b ();

  riscv_regs_bank #(
    .WORD_LENGTH(32), .ADDR_LENGTH(5), .NUM_REGS(32),
    .NUM_READ_PORTS(2), .BYPASS(1), .DEBUG_REG(3)
  ) dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));

  riscv_regs_bank #(
    .WORD_LENGTH(32), .ADDR_LENGTH(5), .NUM_REGS(32),
    .NUM_READ_PORTS(2), .BYPASS(0), .DEBUG_REG(3)
  ) dut_c (.clk(clk), .rst(rst), .bus(if_c.slave));

  riscv_regs_bank #(
    .WORD_LENGTH(32), .ADDR_LENGTH(5), .NUM_REGS(16),
    .NUM_READ_PORTS(3), .BYPASS(1), .DEBUG_REG(3)
  ) dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));

  typedef struct {
    string       tag;
    logic [95:0] exp;
  } sb_item_t;

  sb_item_t sb_q[$];
  int vectors     = 0;
  int miscompares = 0;
  int fa, fb, fc;

  task automatic push(input string tag, input logic [95:0] exp);
    sb_item_t it;
    it.tag = tag;
    it.exp = exp;
    sb_q.push_back(it);
  endtask

  task automatic chk(input logic [95:0] obs);
    sb_item_t it;
    vectors++;
    if (sb_q.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard_empty: observed %h required an expected entry", obs);
    end else begin
      it = sb_q.pop_front();
      assert (obs === it.exp)
      else begin
        miscompares++;
        $error("FAIL %s: observed %h expected %h", it.tag, obs, it.exp);
      end
    end
  endtask

  task automatic drive_ac(input RF_WEN we, input logic [4:0] wa, input logic [31:0] wd,
                          input logic [4:0] r0, input logic [4:0] r1);
    if_a.write_en = we;  if_a.write_addr = wa;  if_a.data = wd;  if_a.read_addr = {r1, r0};
    if_c.write_en = we;  if_c.write_addr = wa;  if_c.data = wd;  if_c.read_addr = {r1, r0};
  endtask

  task automatic drive_b(input RF_WEN we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2);
    if_b.write_en = we;  if_b.write_addr = wa;  if_b.data = wd;  if_b.read_addr = {r2, r1, r0};
  endtask

  // Counts edges until each bank reports ready; 0 means it never did within the budget.
  task automatic count_clear(output int ra, output int rb, output int rc);
    ra = 0; rb = 0; rc = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 4) begin
        drive_ac(RF_NOWRITE, 5'd0, 32'd0, 5'd4, 5'd3);
        drive_b(RF_NOWRITE, 5'd0, 32'd0, 5'd4, 5'd3, 5'd4);
      end
      #1;
      if (k == 2) begin
        push("clear_rd_a", 96'd0);  chk(96'(if_a.read_data));
        push("clear_dbg_a", 96'd0); chk(96'(if_a.debug));
        push("clear_rd_b", 96'd0);  chk(96'(if_b.read_data));
      end
      if (ra == 0 && if_a.ready) ra = k;
      if (rb == 0 && if_b.ready) rb = k;
      if (rc == 0 && if_c.ready) rc = k;
    end
  endtask

  initial begin
    rst = 1'b1;
    drive_ac(RF_NOWRITE, 5'd0, 32'd0, 5'd0, 5'd0);
    drive_b(RF_NOWRITE, 5'd0, 32'd0, 5'd0, 5'd0, 5'd0);
    @(negedge clk);
    @(negedge clk);
    #1;
    push("rst_ready_a", 96'd0); chk(96'(if_a.ready));
    push("rst_ready_b", 96'd0); chk(96'(if_b.ready));
    push("rst_rd_a", 96'd0);    chk(96'(if_a.read_data));

    // Write x4 during clear; it must be dropped.
    rst = 1'b0;
    drive_ac(RF_WRITE, 5'd4, 32'h1, 5'd4, 5'd4);
    drive_b(RF_WRITE, 5'd4, 32'h1, 5'd4, 5'd4, 5'd4);
    count_clear(fa, fb, fc);
    push("clear_len_a", 96'd32); chk(96'(fa));
    push("clear_len_c", 96'd32); chk(96'(fc));
    push("clear_len_b", 96'd16); chk(96'(fb));

    for (int i = 0; i < 32; i++) begin
      drive_ac(RF_NOWRITE, 5'd0, 32'd0, 5'(i), 5'(i));
      drive_b(RF_NOWRITE, 5'd0, 32'd0, 5'(i), 5'(i), 5'(i));
      #1;
      push($sformatf("zero_a_x%0d", i), 96'd0); chk(96'(if_a.read_data));
      push($sformatf("zero_b_x%0d", i), 96'd0); chk(96'(if_b.read_data));
    end

    @(negedge clk);
    drive_ac(RF_WRITE, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0);
    drive_b(RF_WRITE, 5'd20, 32'hAAAA5555, 5'd20, 5'd4, 5'd0);
    #1;
    push("b_rd20_same", 96'd0); chk(96'(if_b.read_data));

    @(negedge clk);
    drive_ac(RF_NOWRITE, 5'd0, 32'd0, 5'd5, 5'd5);
    drive_b(RF_WRITE, 5'd15, 32'hCAFEF00D, 5'd20, 5'd4, 5'd15);
    #1;
    push("a_x5_both", {32'd0, 32'hDEADBEEF, 32'hDEADBEEF}); chk(96'(if_a.read_data));
    push("c_x5_both", {32'd0, 32'hDEADBEEF, 32'hDEADBEEF}); chk(96'(if_c.read_data));
    push("b_drop20_byp15", {32'hCAFEF00D, 32'd0, 32'd0});   chk(96'(if_b.read_data));

    @(negedge clk);
    drive_ac(RF_WRITE, 5'd7, 32'h12345678, 5'd7, 5'd5);
    drive_b(RF_NOWRITE, 5'd0, 32'd0, 5'd15, 5'd15, 5'd20);
    #1;
    push("a_x7_bypass", {32'd0, 32'hDEADBEEF, 32'h12345678}); chk(96'(if_a.read_data));
    push("c_x7_old", {32'd0, 32'hDEADBEEF, 32'h0});           chk(96'(if_c.read_data));
    push("b_x15_stored", {32'd0, 32'hCAFEF00D, 32'hCAFEF00D}); chk(96'(if_b.read_data));

    @(negedge clk);
    drive_ac(RF_WRITE, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd7);
    #1;
    push("a_x0_same", {32'd0, 32'h12345678, 32'h0}); chk(96'(if_a.read_data));
    push("c_x0_same", {32'd0, 32'h12345678, 32'h0}); chk(96'(if_c.read_data));

    @(negedge clk);
    drive_ac(RF_NOWRITE, 5'd0, 32'd0, 5'd0, 5'd7);
    #1;
    push("a_x0_next", {32'd0, 32'h12345678, 32'h0}); chk(96'(if_a.read_data));
    push("c_x0_next", {32'd0, 32'h12345678, 32'h0}); chk(96'(if_c.read_data));

    @(negedge clk);
    drive_ac(RF_WRITE, 5'd3, 32'h1, 5'd3, 5'd5);
    #1;
    push("a_dbg_nobyp", 96'd0);                      chk(96'(if_a.debug));
    push("a_x3_bypass", {32'd0, 32'hDEADBEEF, 32'h1}); chk(96'(if_a.read_data));
    push("c_x3_old", {32'd0, 32'hDEADBEEF, 32'h0});    chk(96'(if_c.read_data));

    @(negedge clk);
    drive_ac(RF_NOWRITE, 5'd0, 32'd0, 5'd3, 5'd3);
    #1;
    push("a_dbg_set", 96'd1); chk(96'(if_a.debug));
    push("c_dbg_set", 96'd1); chk(96'(if_c.debug));
    push("c_x3_new", {32'd0, 32'h1, 32'h1}); chk(96'(if_c.read_data));

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    push("a_dbg_rst", 96'd0);   chk(96'(if_a.debug));
    push("a_ready_rst", 96'd0); chk(96'(if_a.ready));
    push("c_ready_rst", 96'd0); chk(96'(if_c.ready));
    push("a_rd_rst", 96'd0);    chk(96'(if_a.read_data));

    // Let the clear get partway, then restart it.
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive_ac(RF_NOWRITE, 5'd0, 32'd0, 5'd3, 5'd5);
    drive_b(RF_NOWRITE, 5'd0, 32'd0, 5'd15, 5'd3, 5'd15);
    count_clear(fa, fb, fc);
    push("reclear_len_a", 96'd32); chk(96'(fa));
    push("reclear_len_c", 96'd32); chk(96'(fc));
    push("reclear_len_b", 96'd16); chk(96'(fb));

    drive_ac(RF_NOWRITE, 5'd0, 32'd0, 5'd3, 5'd5);
    drive_b(RF_NOWRITE, 5'd0, 32'd0, 5'd15, 5'd3, 5'd15);
    #1;
    push("a_x3_cleared", 96'd0); chk(96'(if_a.read_data));
    push("a_dbg_cleared", 96'd0); chk(96'(if_a.debug));
    push("c_x3_cleared", 96'd0); chk(96'(if_c.read_data));
    push("b_cleared", 96'd0);    chk(96'(if_b.read_data));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
